// File: rtl/icache_axi_refill.sv
// icache_axi_refill: AXI4 read master for I-cache line refill and uncached fetch.
// Optional build macro ICACHE_REFILL_CRITICAL_FIRST_EN selects a critical-word-first WRAP refill.
module icache_axi_refill #(
  parameter logic [3:0] ARID = 4'd0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_req,
  input  logic [31:0]  rd_addr,
  output logic         ret_valid,
  output logic [255:0] ret_data,
  input  logic         uc_ren,
  input  logic [31:0]  uc_addr,
  output logic         uc_rvalid,
  output logic [31:0]  uc_rdata,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  typedef enum logic [2:0] {
    IDLE,
    L_AR,
    L_R,
    L_DONE,
    U_AR,
    U_R,
    U_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr;
  logic [2:0]  r_cnt;
  logic        r_full;
  logic [2:0]  w_widx;
  logic        w_unused;

  assign w_unused = ^{rid, rresp, r_addr[1:0]};

`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
  assign w_widx = r_addr[4:2] + r_cnt;
`else
  assign w_widx = r_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Beats past the eighth are acknowledged but never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr   <= '0;
      r_cnt    <= '0;
      r_full   <= 1'b0;
      ret_data <= '0;
      uc_rdata <= '0;
    end else begin
      if (r_state == IDLE) begin
        r_cnt  <= '0;
        r_full <= 1'b0;
        if (rd_req) begin
          r_addr <= rd_addr;
        end else if (uc_ren) begin
          r_addr <= uc_addr;
        end
      end
      if (r_state == L_R && rvalid && !r_full) begin
        for (int i = 0; i < 8; i++) begin
          if (w_widx == i[2:0]) begin
            ret_data[32*i +: 32] <= rdata;
          end
        end
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          r_full <= 1'b1;
        end
      end
      if (r_state == U_R && rvalid) begin
        uc_rdata <= rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    arid        = ARID;
    araddr      = '0;
    arlen       = '0;
    arsize      = 3'b010;
    arburst     = 2'b01;
    arvalid     = 1'b0;
    rready      = 1'b0;
    ret_valid   = 1'b0;
    uc_rvalid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (rd_req) begin
          w_state_nxt = L_AR;
        end else if (uc_ren) begin
          w_state_nxt = U_AR;
        end
      end
      L_AR: begin
        arvalid = 1'b1;
        arlen   = 8'd7;
`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
        araddr  = {r_addr[31:2], 2'b00};
        arburst = 2'b10;
`else
        araddr  = {r_addr[31:5], 5'b0};
`endif
        if (arready) begin
          w_state_nxt = L_R;
        end
      end
      L_R: begin
        rready = 1'b1;
        if (rvalid && rlast) begin
          w_state_nxt = L_DONE;
        end
      end
      L_DONE: begin
        ret_valid   = 1'b1;
        w_state_nxt = IDLE;
      end
      U_AR: begin
        arvalid = 1'b1;
        araddr  = {r_addr[31:2], 2'b00};
        if (arready) begin
          w_state_nxt = U_R;
        end
      end
      U_R: begin
        rready = 1'b1;
        if (rvalid) begin
          w_state_nxt = U_DONE;
        end
      end
      U_DONE: begin
        uc_rvalid   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
